hbm_axi_pc_responder: RTL

- Synthesizable AXI4 responder (slave) that emulates one HBM pseudo-channel, backed by an on-chip word array.
- Sits on the memory side of one AXI channel and answers the read/write traffic issued by the HBM read/write address-generation engines.
- Enables HBM-less simulation and FPGA bring-up of the input/weight/output datapaths.
- Independent read and write engines; INCR bursts only.

---
 rtl/hbm_axi_pc_responder.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/hbm_axi_pc_responder.sv
// AXI4 slave that emulates one HBM pseudo-channel on top of an on-chip word array.
// Read and write engines are independent, keep one transaction each in flight, and use INCR bursts of 32 B beats.
module hbm_axi_pc_responder #(
    parameter int ADDR_WIDTH = 33,
    parameter int ID_WIDTH   = 5,
    parameter int DATA_WIDTH = 256,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    wstate_t             r_wstate, w_wstate_nxt;
    logic                r_awready, w_awready_nxt;
    logic                r_wready, w_wready_nxt;
    logic                r_bvalid, w_bvalid_nxt;
    logic [ID_WIDTH-1:0] r_bid, w_bid_nxt;
    logic [1:0]          r_bresp, w_bresp_nxt;
    logic [ID_WIDTH-1:0] r_wid, w_wid_nxt;
    logic [IDX_W-1:0]    r_widx, w_widx_nxt;
    logic [7:0]          r_wlen, w_wlen_nxt;
    logic [8:0]          r_wcnt, w_wcnt_nxt;
    logic                w_wr_en;
    logic                w_wcnt_hit;

    rstate_t             r_rstate, w_rstate_nxt;
    logic                r_arready, w_arready_nxt;
    logic                r_rvalid, w_rvalid_nxt;
    logic                r_rlast, w_rlast_nxt;
    logic [ID_WIDTH-1:0] r_rid, w_rid_nxt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [IDX_W-1:0]    r_ridx, w_ridx_nxt;
    logic [7:0]          r_rlen, w_rlen_nxt;
    logic [7:0]          r_rcnt, w_rcnt_nxt;
    logic [7:0]          w_rcnt_inc;
    logic                w_rload;
    logic [IDX_W-1:0]    w_rload_idx;

    // Byte offset and address bits above the array size do not select a word.
    logic w_unused_addr;
    assign w_unused_addr = ^{s_axi_awaddr[4:0], s_axi_awaddr[ADDR_WIDTH-1:5+IDX_W],
                             s_axi_araddr[4:0], s_axi_araddr[ADDR_WIDTH-1:5+IDX_W]};

    assign w_wcnt_hit = (r_wcnt == {1'b0, r_wlen});

    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bid_nxt     = r_bid;
        w_bresp_nxt   = r_bresp;
        w_wid_nxt     = r_wid;
        w_widx_nxt    = r_widx;
        w_wlen_nxt    = r_wlen;
        w_wcnt_nxt    = r_wcnt;
        w_wr_en       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready_nxt = 1'b1;
                if (s_axi_awvalid && r_awready) begin
                    w_wid_nxt     = s_axi_awid;
                    w_widx_nxt    = s_axi_awaddr[5 +: IDX_W];
                    w_wlen_nxt    = s_axi_awlen;
                    w_wcnt_nxt    = '0;
                    w_awready_nxt = 1'b0;
                    w_wready_nxt  = 1'b1;
                    w_wstate_nxt  = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid && r_wready) begin
                    w_wr_en    = 1'b1;
                    w_widx_nxt = r_widx + 1'b1;
                    w_wcnt_nxt = r_wcnt + 9'd1;
                    // Either wlast or the beat count closes the burst; OKAY needs both together.
                    if (s_axi_wlast || w_wcnt_hit) begin
                        w_wready_nxt = 1'b0;
                        w_bvalid_nxt = 1'b1;
                        w_bid_nxt    = r_wid;
                        w_bresp_nxt  = (s_axi_wlast && w_wcnt_hit) ? 2'b00 : 2'b10;
                        w_wstate_nxt = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wstate_nxt  = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= '0;
            r_wid     <= '0;
            r_widx    <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bid     <= w_bid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_wid     <= w_wid_nxt;
            r_widx    <= w_widx_nxt;
            r_wlen    <= w_wlen_nxt;
            r_wcnt    <= w_wcnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    r_mem[r_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign w_rcnt_inc = r_rcnt + 8'd1;

    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rlast_nxt   = r_rlast;
        w_rid_nxt     = r_rid;
        w_ridx_nxt    = r_ridx;
        w_rlen_nxt    = r_rlen;
        w_rcnt_nxt    = r_rcnt;
        w_rload       = 1'b0;
        w_rload_idx   = r_ridx;
        case (r_rstate)
            R_IDLE: begin
                w_arready_nxt = 1'b1;
                if (s_axi_arvalid && r_arready) begin
                    w_arready_nxt = 1'b0;
                    w_rload       = 1'b1;
                    w_rload_idx   = s_axi_araddr[5 +: IDX_W];
                    w_ridx_nxt    = s_axi_araddr[5 +: IDX_W] + 1'b1;
                    w_rid_nxt     = s_axi_arid;
                    w_rlen_nxt    = s_axi_arlen;
                    w_rcnt_nxt    = '0;
                    w_rlast_nxt   = (s_axi_arlen == 8'd0);
                    w_rvalid_nxt  = 1'b1;
                    w_rstate_nxt  = R_DATA;
                end
            end
            R_DATA: begin
                if (r_rvalid && s_axi_rready) begin
                    if (!r_rlast) begin
                        w_rload     = 1'b1;
                        w_ridx_nxt  = r_ridx + 1'b1;
                        w_rcnt_nxt  = w_rcnt_inc;
                        w_rlast_nxt = (w_rcnt_inc == r_rlen);
                    end else begin
                        w_rvalid_nxt  = 1'b0;
                        w_rlast_nxt   = 1'b0;
                        w_arready_nxt = 1'b1;
                        w_rstate_nxt  = R_IDLE;
                    end
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // The array read uses pre-edge contents, so a same-cycle write to that word is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_ridx    <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rlast   <= w_rlast_nxt;
            r_rid     <= w_rid_nxt;
            r_ridx    <= w_ridx_nxt;
            r_rlen    <= w_rlen_nxt;
            r_rcnt    <= w_rcnt_nxt;
            if (w_rload) begin
                r_rdata <= r_mem[w_rload_idx];
            end
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bid     = r_bid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = 2'b00;

endmodule
